// File: rtl/d5m_sensor_emulator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | d5m_pkg: shared state encoding and pattern codes for the D5M model  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package d5m_pkg;

  typedef logic [1:0] pat_sel_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FOT    = 3'd1;
  localparam logic [2:0] ST_ACTIVE = 3'd2;
  localparam logic [2:0] ST_HBLANK = 3'd3;
  localparam logic [2:0] ST_LOT    = 3'd4;
  localparam logic [2:0] ST_VBLANK = 3'd5;

  localparam pat_sel_t PAT_COL   = 2'd0;
  localparam pat_sel_t PAT_ROW   = 2'd1;
  localparam pat_sel_t PAT_DIAG  = 2'd2;
  localparam pat_sel_t PAT_CONST = 2'd3;

  localparam logic [7:0] PAT_CONST_VAL = 8'hA5;

endpackage
`default_nettype wire

// File: rtl/d5m_sensor_emulator_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | d5m_sensor_emulator_if: control inputs and camera-pin outputs      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface d5m_sensor_emulator_if;
  import d5m_pkg::*;

  logic        enable;
  pat_sel_t    pattern_sel;
  logic        frame_valid;
  logic        line_valid;
  logic [7:0]  data_out;
  logic [15:0] frame_count;
  logic        busy;

  modport master (
    input  enable, pattern_sel,
    output frame_valid, line_valid, data_out, frame_count, busy
  );

  modport slave (
    output enable, pattern_sel,
    input  frame_valid, line_valid, data_out, frame_count, busy
  );

endinterface
`default_nettype wire

// File: rtl/d5m_sensor_emulator_pattern_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | d5m_pattern_gen: combinational test-pattern pixel from position    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module d5m_pattern_gen
  import d5m_pkg::*;
#(
  parameter int CW = 12,
  parameter int RW = 11
) (
  input  pat_sel_t       sel_i,
  input  logic [CW-1:0]  col_i,
  input  logic [RW-1:0]  row_i,
  input  logic [7:0]     frame_i,
  output logic [7:0]     pix_o
);

  logic [7:0] w_col8;
  logic [7:0] w_row8;

  // Size casts truncate wide counters and zero-extend narrow ones alike.
  assign w_col8 = 8'(col_i);
  assign w_row8 = 8'(row_i);

  always_comb begin
    pix_o = PAT_CONST_VAL;
    case (sel_i)
      PAT_COL:  pix_o = w_col8;
      PAT_ROW:  pix_o = w_row8;
      PAT_DIAG: pix_o = w_col8 + w_row8 + frame_i;
      default:  pix_o = PAT_CONST_VAL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/d5m_sensor_emulator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | d5m_sensor_emulator: FV/LV/pixel timing generator for D5M bring-up |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module d5m_sensor_emulator
  import d5m_pkg::*;
#(
  parameter int COLS   = 2592,
  parameter int LINES  = 1944,
  parameter int FOT    = 8,
  parameter int HBLANK = 16,
  parameter int LOT    = 8,
  parameter int VBLANK = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  d5m_sensor_emulator_if.master bus
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(LINES);

  localparam logic [CW-1:0] c_col_last    = CW'(COLS - 1);
  localparam logic [RW-1:0] c_row_last    = RW'(LINES - 1);
  localparam logic [15:0]   c_fot_last    = 16'(FOT - 1);
  localparam logic [15:0]   c_hblank_last = 16'(HBLANK - 1);
  localparam logic [15:0]   c_lot_last    = 16'(LOT - 1);
  localparam logic [15:0]   c_vblank_last = 16'(VBLANK - 1);

  logic [2:0]    state_q,  state_d;
  logic [15:0]   cnt_q,    cnt_d;
  logic [CW-1:0] col_q,    col_d;
  logic [RW-1:0] row_q,    row_d;
  logic          fv_q,     fv_d;
  logic          lv_q,     lv_d;
  logic [7:0]    data_q,   data_d;
  logic [15:0]   fc_q,     fc_d;
  logic          busy_q,   busy_d;
  pat_sel_t      sel_q,    sel_d;
  logic [7:0]    frame_q,  frame_d;
  logic          w_start;
  logic [7:0]    w_pix;

  // enable is only honoured in IDLE and on the last VBLANK cycle.
  assign w_start = bus.enable &&
                   ((state_q == ST_IDLE) ||
                    ((state_q == ST_VBLANK) && (cnt_q == c_vblank_last)));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    fv_d    = fv_q;
    lv_d    = lv_q;
    fc_d    = fc_q;
    sel_d   = sel_q;
    frame_d = frame_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 16'd0;
      end
      ST_FOT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == c_fot_last) begin
          state_d = ST_ACTIVE;
          lv_d    = 1'b1;
          col_d   = '0;
          cnt_d   = 16'd0;
        end
      end
      ST_ACTIVE: begin
        col_d = col_q + CW'(1);
        if (col_q == c_col_last) begin
          lv_d    = 1'b0;
          col_d   = col_q;
          cnt_d   = 16'd0;
          state_d = (row_q == c_row_last) ? ST_LOT : ST_HBLANK;
        end
      end
      ST_HBLANK: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == c_hblank_last) begin
          state_d = ST_ACTIVE;
          lv_d    = 1'b1;
          col_d   = '0;
          row_d   = row_q + RW'(1);
          cnt_d   = 16'd0;
        end
      end
      ST_LOT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == c_lot_last) begin
          state_d = ST_VBLANK;
          fv_d    = 1'b0;
          fc_d    = fc_q + 16'd1;
          cnt_d   = 16'd0;
        end
      end
      ST_VBLANK: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == c_vblank_last) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        fv_d    = 1'b0;
        lv_d    = 1'b0;
        cnt_d   = 16'd0;
      end
    endcase

    // Frame start overrides the IDLE / end-of-VBLANK decisions above.
    if (w_start) begin
      state_d = ST_FOT;
      fv_d    = 1'b1;
      cnt_d   = 16'd0;
      col_d   = '0;
      row_d   = '0;
      sel_d   = bus.pattern_sel;
      frame_d = fc_q[7:0];
    end
  end

  // Pixel is computed for the position that will be on the pins next cycle.
  d5m_pattern_gen #(
    .CW (CW),
    .RW (RW)
  ) u_pattern_gen (
    .sel_i   (sel_d),
    .col_i   (col_d),
    .row_i   (row_d),
    .frame_i (frame_d),
    .pix_o   (w_pix)
  );

  assign data_d = lv_d ? w_pix : 8'd0;
  assign busy_d = (state_d != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 16'd0;
      col_q   <= '0;
      row_q   <= '0;
      fv_q    <= 1'b0;
      lv_q    <= 1'b0;
      data_q  <= 8'd0;
      fc_q    <= 16'd0;
      busy_q  <= 1'b0;
      sel_q   <= PAT_COL;
      frame_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      fv_q    <= fv_d;
      lv_q    <= lv_d;
      data_q  <= data_d;
      fc_q    <= fc_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
    end
  end

  assign bus.frame_valid = fv_q;
  assign bus.line_valid  = lv_q;
  assign bus.data_out    = data_q;
  assign bus.frame_count = fc_q;
  assign bus.busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_d5m_sensor_emulator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_d5m_sensor_emulator: directed checks of D5M frame/line timing   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_d5m_sensor_emulator;
  import d5m_pkg::*;

  localparam int TC = 4;
  localparam int TL = 3;
  localparam int TF = 3;
  localparam int TH = 2;
  localparam int TO = 2;
  localparam int TV = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  d5m_sensor_emulator_if bus ();

  d5m_sensor_emulator #(
    .COLS   (TC),
    .LINES  (TL),
    .FOT    (TF),
    .HBLANK (TH),
    .LOT    (TO),
    .VBLANK (TV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference timing: k counts cycles from the first FV-high cycle of a frame.
  function automatic bit m_fv(input int k);
    return (k >= 0) && (k < TF + TL*TC + (TL-1)*TH + TO);
  endfunction

  function automatic int m_row(input int k);
    for (int r = 0; r < TL; r++)
      if (k >= TF + r*(TC+TH) && k < TF + r*(TC+TH) + TC) return r;
    return -1;
  endfunction

  function automatic bit m_lv(input int k);
    return m_row(k) >= 0;
  endfunction

  function automatic int m_col(input int k);
    return k - TF - m_row(k)*(TC+TH);
  endfunction

  function automatic logic [7:0] m_pix(input int sel, input int col, input int row, input int frame);
    case (sel)
      0:       return 8'(col % 256);
      1:       return 8'(row % 256);
      2:       return 8'((col + row + frame) % 256);
      default: return 8'hA5;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chkint(input string tag, input int obs, input int exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  initial begin
    int bad;
    int lvcnt;
    int fvcnt;
    logic [7:0] e;

    bus.enable      = 1'b0;
    bus.pattern_sel = PAT_COL;

    // Reset and idle hold
    repeat (3) tick;
    chk1 ("rst_fv",   bus.frame_valid, 1'b0);
    chk1 ("rst_lv",   bus.line_valid,  1'b0);
    chk8 ("rst_data", bus.data_out,    8'd0);
    chk16("rst_fc",   bus.frame_count, 16'd0);
    chk1 ("rst_busy", bus.busy,        1'b0);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      tick;
      if (bus.frame_valid || bus.line_valid || bus.busy ||
          bus.data_out != 8'd0 || bus.frame_count != 16'd0) bad++;
    end
    chkint("idle_activity", bad, 0);
    chk16 ("idle_fc",   bus.frame_count, 16'd0);
    chk1  ("idle_busy", bus.busy, 1'b0);

    // Single frame, column ramp, one-cycle enable pulse
    bus.enable = 1'b1;
    tick;
    bus.enable = 1'b0;
    for (int k = 0; k < 26; k++) begin
      e = m_lv(k) ? m_pix(0, m_col(k), m_row(k), 0) : 8'd0;
      chk1($sformatf("single_fv_k%0d", k), bus.frame_valid, m_fv(k));
      chk1($sformatf("single_lv_k%0d", k), bus.line_valid,  m_lv(k));
      chk8($sformatf("single_data_k%0d", k), bus.data_out, e);
      if (k == 20) chk16("single_fc_before_fall", bus.frame_count, 16'd0);
      if (k == 21) chk16("single_fc_at_fall",     bus.frame_count, 16'd1);
      if (k == 25) chk1 ("single_busy_vblank",    bus.busy, 1'b1);
      tick;
    end
    chk1 ("single_idle_busy", bus.busy, 1'b0);
    chk1 ("single_idle_fv",   bus.frame_valid, 1'b0);
    chk16("single_fc",        bus.frame_count, 16'd1);

    // Continuous diagonal frames, then enable drop during row 1 of frame 3
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    bus.enable      = 1'b1;
    bus.pattern_sel = PAT_DIAG;
    tick;
    lvcnt = 0;
    fvcnt = 0;
    for (int k = 0; k <= 140; k++) begin
      if (k == 0 || k == 26 || k == 52 || k == 78)
        chk1($sformatf("cont_fv_rise_k%0d", k), bus.frame_valid, 1'b1);
      if (k == 25 || k == 51 || k == 77)
        chk1($sformatf("cont_fv_low_k%0d", k), bus.frame_valid, 1'b0);
      if (k >= 35 && k <= 38)
        chk8($sformatf("cont_diag_f1r1_k%0d", k), bus.data_out, m_pix(2, k - 35, 1, 1));
      if (k == 72) chk16("cont_fc_before_3rd_fall", bus.frame_count, 16'd2);
      if (k == 73) chk16("cont_fc_after_3rd_fall",  bus.frame_count, 16'd3);
      if (k == 88) chk1 ("drop_lv_row1", bus.line_valid, 1'b1);
      if (k == 103) chk1("drop_busy_last_vblank", bus.busy, 1'b1);
      if (k == 104) chk1("drop_busy_idle", bus.busy, 1'b0);
      if (k >= 78 && bus.line_valid) lvcnt++;
      if (k >= 99 && bus.frame_valid) fvcnt++;
      if (k == 88) bus.enable = 1'b0;
      tick;
    end
    chkint("drop_lv_cycles", lvcnt, 12);
    chkint("drop_fv_after",  fvcnt, 0);
    chk16 ("drop_fc",        bus.frame_count, 16'd4);

    // Pattern switch mid-frame takes effect on the following frame
    bus.pattern_sel = PAT_COL;
    bus.enable      = 1'b1;
    tick;
    for (int k = 0; k < 56; k++) begin
      if (k < 26 && m_lv(k))
        chk8($sformatf("patsw_col_k%0d", k), bus.data_out, 8'(m_col(k)));
      if (k >= 26 && m_lv(k - 26))
        chk8($sformatf("patsw_row_k%0d", k), bus.data_out, 8'(m_row(k - 26)));
      if (k == 10) bus.pattern_sel = PAT_ROW;
      if (k == 27) bus.enable = 1'b0;
      tick;
    end
    chk1 ("patsw_idle_busy", bus.busy, 1'b0);
    chk16("patsw_fc",        bus.frame_count, 16'd6);

    // Asynchronous reset while a line is active
    bus.pattern_sel = PAT_COL;
    bus.enable      = 1'b1;
    tick;
    repeat (5) tick;
    chk1("arst_lv_before", bus.line_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1 ("arst_fv",   bus.frame_valid, 1'b0);
    chk1 ("arst_lv",   bus.line_valid,  1'b0);
    chk8 ("arst_data", bus.data_out,    8'd0);
    chk16("arst_fc",   bus.frame_count, 16'd0);
    chk1 ("arst_busy", bus.busy,        1'b0);
    tick;
    rst_n = 1'b1;
    tick;
    chk1("rel_fv_k0", bus.frame_valid, 1'b1);
    chk1("rel_lv_k0", bus.line_valid,  1'b0);
    repeat (3) tick;
    chk1("rel_lv_k3",   bus.line_valid, 1'b1);
    chk8("rel_data_k3", bus.data_out,   8'd0);
    bus.enable = 1'b0;
    tick;
    chk8("rel_data_k4", bus.data_out, 8'd1);
    repeat (30) tick;
    chk1 ("rel_end_busy", bus.busy, 1'b0);
    chk16("rel_end_fc",   bus.frame_count, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
